mpu_iic_sequencer: RTL and testbench
====================================

# mpu_iic_sequencer

Sequencer that owns the `std_iic_master` byte engine and drives the MPU-6050 attitude sensor. After reset it writes a fixed five-register init table, then at a fixed sample rate issues two burst reads (accel, gyro) and assembles the 12 returned bytes into six signed 16-bit words for the attitude filter. It is the only client of the I2C master; nothing else drives `en_start`.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency
- `SAMPLE_HZ`, 1000, sample trigger rate
- `PWRUP_CYC`, 5_000_000, delay after reset before the first transaction (100 ms)
- `TIMEOUT_CYC`, 2_000_000, watchdog limit per transaction (only with `MPU_SEQ_TIMEOUT_EN`)
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `iic_en_start` out 1: one-cycle start pulse to the master
- `iic_n_send` out 3: bytes written after the device address
- `iic_m_read` out 3: bytes to read minus 1
- `iic_read_now` out 1: 1 means a repeated-start read follows the writes
- `iic_tx_data` out 8: current write byte
- `iic_send_done` in 1: one-cycle pulse per transmitted byte; advances `iic_tx_data`
- `iic_busy` in 1: master transaction in progress
- `iic_data_avalid` in 1: one-cycle pulse, `iic_data` is valid
- `iic_data` in 8: received byte
- `accel_x`, `accel_y`, `accel_z`, `gyro_x`, `gyro_y`, `gyro_z` out 16 each: signed samples
- `sample_valid` out 1: one-cycle pulse when all six words update
- `init_done` out 1: level, set once the init table completes
- `err` out 1: sticky error flag, cleared only by `rst`

## Operation
- States: `PWRUP`, `INIT_ISSUE`, `INIT_WAIT`, `IDLE`, `ACC_ISSUE`, `ACC_WAIT`, `GYR_ISSUE`, `GYR_WAIT`, `PUBLISH`.
- `PWRUP`: count `PWRUP_CYC` cycles, then go to `INIT_ISSUE` with index 0.
- Init table, as {reg, value}: {0x6B,0x00}, {0x19,0x07}, {0x1A,0x06}, {0x1B,0x18}, {0x1C,0x01}.
- `INIT_ISSUE`: wait for `iic_busy`=0, then pulse start with `n_send`=2, `read_now`=0, `tx_data`=reg. Move to `INIT_WAIT`.
- `INIT_WAIT`: on the first `send_done`, `tx_data` becomes value. On falling `iic_busy`, increment index. After index 4, set `init_done` and go to `IDLE`; otherwise return to `INIT_ISSUE`.
- `IDLE`: a free-running tick every `CLK_HZ/SAMPLE_HZ` cycles moves to `ACC_ISSUE`. A tick that arrives while a read is in flight is dropped, not queued.
- `ACC_ISSUE`: start with `n_send`=1, `tx_data`=0x3B, `read_now`=1, `m_read`=5.
- `GYR_ISSUE`: same transaction with `tx_data`=0x43. Temperature registers are not read.
- Each `data_avalid` writes the shadow byte `[byte_cnt]` (0–11) and increments `byte_cnt`. Bytes are big-endian: even index is the high byte.
- `PUBLISH`: copy the shadows to the outputs in the same cycle and pulse `sample_valid`. Go to `IDLE`.
- Fewer than 6 bytes before falling `iic_busy`: set `err`, discard the shadows, go to `IDLE`. The outputs keep their old values and there is no `sample_valid`.
- More than 6 `data_avalid` pulses in one burst: the extra bytes are ignored.

## Timing
- Reset values: `iic_en_start`=0, `iic_n_send`=0, `iic_m_read`=0, `iic_read_now`=0, `iic_tx_data`=0x00, all sample words 0, `sample_valid`=0, `init_done`=0, `err`=0, state `PWRUP`.
- `iic_n_send`, `iic_m_read`, `iic_read_now` and `iic_tx_data` are valid in the cycle of the start pulse. They stay stable until `iic_busy` falls, except that `tx_data` advances on `send_done`.
- Start pulse timing: `iic_en_start` is asserted in the first `*_ISSUE` cycle in which `iic_busy`=0, and lasts exactly one cycle.
- `sample_valid` is asserted 1 cycle after `iic_busy` falls at the end of the gyro burst.
- `rst` mid-transaction returns to `PWRUP` at once. A partial sample is never published.

## Configuration
- `MPU_SEQ_TIMEOUT_EN` defined:
  - A per-transaction counter starts at each start pulse.
  - If it reaches `TIMEOUT_CYC` while in `*_WAIT`, set `err` and abandon the transaction.
  - A timeout during init restarts the init table from index 0 (no power-up delay).
  - A timeout during a read returns to `IDLE`.
- `MPU_SEQ_TIMEOUT_EN` undefined: no counter; a hung master stalls the sequencer.

## Structure
- Package `mpu_pkg`:
  - state enum
  - init table constant (5×16)
  - register constants `REG_ACCEL_XOUT_H`=0x3B and `REG_GYRO_XOUT_H`=0x43
  - `INIT_LEN`=5
- Sub-module `mpu_rate_tick`: parameterised divider producing the one-cycle sample tick.

## Test plan
- Reset release with `PWRUP_CYC`=100 and a master model → after 100 cycles, five write transactions carry bytes 6B/00, 19/07, 1A/06, 1B/18, 1C/01, then `init_done`=1.
- Model returns accel 12 34 FF FE 00 01 and gyro 80 00 7F FF 00 00 → `accel_x`=0x1234, `accel_y`=−2, `accel_z`=1, `gyro_x`=−32768, `gyro_y`=32767, `gyro_z`=0, and one `sample_valid` pulse.
- Model stretches `iic_busy` past one tick period → the tick is dropped: exactly one read pair per completed sample and no back-to-back start.
- Model returns only 4 bytes in the gyro burst → `err`=1, the outputs are unchanged, and there is no `sample_valid`.
- `rst` asserted during `GYR_WAIT` → all outputs return to reset values in the next cycle, and the power-up delay restarts.
- With `MPU_SEQ_TIMEOUT_EN` and `TIMEOUT_CYC`=50, model holds `iic_busy` high during the third init write → `err`=1 and the init table restarts at 0x6B.

Source files
------------

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared states, register addresses and the MPU-6050 init table
package mpu_pkg;
  typedef enum logic [3:0] {
    PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, ACC_ISSUE, ACC_WAIT, GYR_ISSUE, GYR_WAIT, PUBLISH
  } state_t;
  localparam int INIT_LEN = 5;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_GYRO_XOUT_H = 8'h43;
  localparam logic [INIT_LEN-1:0][15:0] INIT_TABLE = {16'h1C01, 16'h1B18, 16'h1A06, 16'h1907, 16'h6B00};
endpackage

// File: rtl/mpu_iic_sequencer_if.sv
// mpu_iic_sequencer_if: command/response signals between the sequencer and the I2C byte engine
interface mpu_iic_sequencer_if;
  logic en_start;
  logic [2:0] n_send;
  logic [2:0] m_read;
  logic read_now;
  logic [7:0] tx_data;
  logic send_done;
  logic busy;
  logic data_avalid;
  logic [7:0] data;
  modport master(output en_start, n_send, m_read, read_now, tx_data, input send_done, busy, data_avalid, data);
  modport slave(input en_start, n_send, m_read, read_now, tx_data, output send_done, busy, data_avalid, data);
endinterface

// File: rtl/mpu_rate_tick.sv
// mpu_rate_tick: free-running divider emitting a one-cycle tick every DIV cycles
module mpu_rate_tick #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  // wrap at the terminal count so ticks stay periodic regardless of the consumer
  always_ff @(posedge clk) cnt <= (rst || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mpu_iic_sequencer.sv
// mpu_iic_sequencer: MPU-6050 init writer and periodic accel/gyro burst reader; define MPU_SEQ_TIMEOUT_EN for the per-transaction watchdog
module mpu_iic_sequencer
  import mpu_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 1000,
  parameter int PWRUP_CYC   = 5_000_000,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  mpu_iic_sequencer_if.master iic,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic sample_valid,
  output logic init_done,
  output logic err
);
  state_t state, next;
  logic tick, busy_q, fall, to, sent_first, init_st, acc_st, gyr_st, rd_st, capture, short_burst, load, last_idx;
  logic [31:0] pcnt;
  logic [2:0] idx;
  logic [3:0] byte_cnt;
  logic [7:0] shadow [12];

  mpu_rate_tick #(.DIV(CLK_HZ / SAMPLE_HZ)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  assign init_st = state == INIT_ISSUE || state == INIT_WAIT;
  assign acc_st = state == ACC_ISSUE || state == ACC_WAIT;
  assign gyr_st = state == GYR_ISSUE || state == GYR_WAIT;
  assign rd_st = acc_st || gyr_st;
  assign fall = busy_q & ~iic.busy;
  assign last_idx = idx == 3'(INIT_LEN - 1);
  assign capture = iic.data_avalid && ((state == ACC_WAIT && byte_cnt < 4'd6) || (state == GYR_WAIT && byte_cnt < 4'd12));
  assign short_burst = fall && ((state == ACC_WAIT && byte_cnt < 4'd6) || (state == GYR_WAIT && byte_cnt < 4'd12));
  assign load = state == GYR_WAIT && fall && byte_cnt == 4'd12 && !to;

`ifdef MPU_SEQ_TIMEOUT_EN
  logic [31:0] tcnt;
  // watchdog restarted by every start pulse, saturating at the limit
  always_ff @(posedge clk) tcnt <= (rst || iic.en_start) ? '0 : tcnt == 32'(TIMEOUT_CYC - 1) ? tcnt : tcnt + 32'd1;
  assign to = (state == INIT_WAIT || state == ACC_WAIT || state == GYR_WAIT) && tcnt == 32'(TIMEOUT_CYC - 1);
`else
  assign to = TIMEOUT_CYC < 0;
`endif

  // state register
  always_ff @(posedge clk) state <= rst ? PWRUP : next;

  // next-state logic; a timeout outranks a completing transaction
  always_comb begin
    next = state;
    case (state)
      PWRUP:      next = pcnt == 32'(PWRUP_CYC - 1) ? INIT_ISSUE : PWRUP;
      INIT_ISSUE: next = iic.busy ? INIT_ISSUE : INIT_WAIT;
      INIT_WAIT:  next = to ? INIT_ISSUE : !fall ? INIT_WAIT : last_idx ? IDLE : INIT_ISSUE;
      IDLE:       next = tick ? ACC_ISSUE : IDLE;
      ACC_ISSUE:  next = iic.busy ? ACC_ISSUE : ACC_WAIT;
      ACC_WAIT:   next = (to || short_burst) ? IDLE : fall ? GYR_ISSUE : ACC_WAIT;
      GYR_ISSUE:  next = iic.busy ? GYR_ISSUE : GYR_WAIT;
      GYR_WAIT:   next = (to || short_burst) ? IDLE : fall ? PUBLISH : GYR_WAIT;
      default:    next = IDLE;
    endcase
  end

  // counters, flags and published sample words
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      pcnt <= '0;
      idx <= '0;
      sent_first <= 1'b0;
      byte_cnt <= '0;
      init_done <= 1'b0;
      err <= 1'b0;
      {accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z} <= '0;
    end else begin
      busy_q <= iic.busy;
      pcnt <= state == PWRUP ? pcnt + 32'd1 : '0;
      sent_first <= state == INIT_WAIT && (sent_first || iic.send_done);
      if (state == INIT_WAIT && (to || fall)) idx <= (to || last_idx) ? '0 : idx + 3'd1;
      if (state == INIT_WAIT && fall && !to && last_idx) init_done <= 1'b1;
      if (to || short_burst) err <= 1'b1;
      if (iic.en_start && state == ACC_ISSUE) byte_cnt <= '0;
      else if (capture) byte_cnt <= byte_cnt + 4'd1;
      if (load) begin
        accel_x <= {shadow[0], shadow[1]};
        accel_y <= {shadow[2], shadow[3]};
        accel_z <= {shadow[4], shadow[5]};
        gyro_x <= {shadow[6], shadow[7]};
        gyro_y <= {shadow[8], shadow[9]};
        gyro_z <= {shadow[10], shadow[11]};
      end
    end
  end

  // shadow bytes only become visible through a completed gyro burst
  always_ff @(posedge clk) if (capture) shadow[byte_cnt] <= iic.data;

  // master command outputs, held by state until busy falls
  always_comb begin
    iic.en_start = (state == INIT_ISSUE || state == ACC_ISSUE || state == GYR_ISSUE) && !iic.busy;
    iic.n_send = init_st ? 3'd2 : rd_st ? 3'd1 : 3'd0;
    iic.m_read = rd_st ? 3'd5 : 3'd0;
    iic.read_now = rd_st;
    iic.tx_data = init_st ? (sent_first ? INIT_TABLE[idx][7:0] : INIT_TABLE[idx][15:8]) :
                  acc_st ? REG_ACCEL_XOUT_H : gyr_st ? REG_GYRO_XOUT_H : 8'h00;
    sample_valid = state == PUBLISH;
  end
endmodule

// File: tb/tb_mpu_iic_sequencer.sv
// tb_mpu_iic_sequencer: directed bench with a behavioural I2C master model
module tb_mpu_iic_sequencer;
  localparam int CLK_HZ = 200_000, SAMPLE_HZ = 1000, PWRUP_CYC = 100, TIMEOUT_CYC = 50;
  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  logic clk = 1'b0, rst = 1'b1;
  logic signed [15:0] ax, ay, az, gx, gy, gz;
  logic sample_valid, init_done, err;
  mpu_iic_sequencer_if iic();
  mpu_iic_sequencer #(.CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .PWRUP_CYC(PWRUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .iic(iic),
    .accel_x(ax), .accel_y(ay), .accel_z(az), .gyro_x(gx), .gyro_y(gy), .gyro_z(gz),
    .sample_valid(sample_valid), .init_done(init_done), .err(err)
  );
  always #5 clk = ~clk;

  int passed = 0, total = 0, cyc = 0, start_cnt = 0, sv_cnt = 0, stretch = 0;
  int init_wr_cnt = 0, gyro_end_cyc = 0, short_done = 0, m_ns, m_nr;
  bit short_gyro = 0, hang_third = 0, in_gyr = 0, m_rn, m_gy;
  logic [7:0] wr_log[$];
  int nsend_log[$];
  bit rnow_log[$];
  logic [7:0] acc_b[6] = '{8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h01};
  logic [7:0] gyr_b[6] = '{8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h00};
  logic [7:0] init_exp[10] = '{8'h6B, 8'h00, 8'h19, 8'h07, 8'h1A, 8'h06, 8'h1B, 8'h18, 8'h1C, 8'h01};

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (iic.en_start === 1'b1) start_cnt++;
    if (sample_valid === 1'b1) sv_cnt++;
  end

  initial begin
    iic.busy = 0; iic.send_done = 0; iic.data_avalid = 0; iic.data = 0;
    forever begin
      @(negedge clk);
      if (iic.en_start === 1'b1) begin
        m_ns = int'(iic.n_send); m_nr = int'(iic.m_read) + 1; m_rn = iic.read_now;
        m_gy = m_rn && iic.tx_data == 8'h43;
        nsend_log.push_back(m_ns); rnow_log.push_back(m_rn);
        in_gyr = m_gy;
        if (!m_rn) init_wr_cnt++;
        @(negedge clk); iic.busy = 1;
        for (int k = 0; k < m_ns; k++) begin
          @(negedge clk); wr_log.push_back(iic.tx_data); iic.send_done = 1;
          @(negedge clk); iic.send_done = 0;
        end
        if (!m_rn && hang_third && init_wr_cnt == 3) repeat (120) @(negedge clk);
        if (m_rn) for (int k = 0; k < m_nr; k++) begin
          if (m_gy && short_gyro && k >= 4) break;
          iic.data = m_gy ? gyr_b[k] : acc_b[k]; iic.data_avalid = 1;
          @(negedge clk); iic.data_avalid = 0;
          @(negedge clk);
        end
        repeat (stretch) @(negedge clk);
        iic.busy = 0;
        if (m_gy) begin gyro_end_cyc = cyc; in_gyr = 0; if (short_gyro) short_done++; end
      end
    end
  end

  task automatic test_reset(input int hold);
    rst = 1;
    repeat (hold) @(negedge clk);
    total++; if (iic.en_start !== 1'b0) $display("FAIL rst_en_start: got %b expected 0", iic.en_start); else passed++;
    total++; if (iic.n_send !== 3'd0) $display("FAIL rst_n_send: got %0d expected 0", iic.n_send); else passed++;
    total++; if (iic.m_read !== 3'd0) $display("FAIL rst_m_read: got %0d expected 0", iic.m_read); else passed++;
    total++; if (iic.read_now !== 1'b0) $display("FAIL rst_read_now: got %b expected 0", iic.read_now); else passed++;
    total++; if (iic.tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h expected 00", iic.tx_data); else passed++;
    total++; if ({ax, ay, az, gx, gy, gz} !== 96'h0) $display("FAIL rst_samples: got %h expected 0", {ax, ay, az, gx, gy, gz}); else passed++;
    total++; if ({sample_valid, init_done, err} !== 3'b000) $display("FAIL rst_flags: got %b expected 000", {sample_valid, init_done, err}); else passed++;
    wr_log.delete(); nsend_log.delete(); rnow_log.delete();
    rst = 0;
  endtask

  task automatic test_pwrup();
    bit early = 0;
    for (int i = 1; i < PWRUP_CYC; i++) begin
      @(negedge clk);
      if (iic.en_start === 1'b1) early = 1;
    end
    @(negedge clk);
    total++; if (early !== 1'b0) $display("FAIL pwrup_early_start: got %b expected 0", early); else passed++;
    total++; if (iic.en_start !== 1'b1) $display("FAIL pwrup_start: got %b expected 1", iic.en_start); else passed++;
    total++; if (iic.tx_data !== 8'h6B) $display("FAIL pwrup_first_reg: got %h expected 6b", iic.tx_data); else passed++;
  endtask

  task automatic test_init();
    for (int n = 0; n < 1000 && init_done !== 1'b1; n++) @(negedge clk);
    total++; if (init_done !== 1'b1) $display("FAIL init_done: got %b expected 1", init_done); else passed++;
    total++; if (wr_log.size() != 10) $display("FAIL init_len: got %0d expected 10", wr_log.size()); else passed++;
    for (int i = 0; i < 10; i++) begin
      total++; if (wr_log[i] !== init_exp[i]) $display("FAIL init_byte%0d: got %h expected %h", i, wr_log[i], init_exp[i]); else passed++;
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (nsend_log[i] != 2 || rnow_log[i] != 0) $display("FAIL init_txn%0d: got n_send %0d read_now %0d expected 2 0", i, nsend_log[i], rnow_log[i]); else passed++;
    end
  endtask

  task automatic test_sample();
    for (int n = 0; n < 1000 && sample_valid !== 1'b1; n++) @(negedge clk);
    total++; if (sample_valid !== 1'b1) $display("FAIL sample_timeout: got %b expected 1", sample_valid); else passed++;
    total++; if (ax !== 16'sh1234) $display("FAIL accel_x: got %h expected 1234", ax); else passed++;
    total++; if (ay !== -16'sd2) $display("FAIL accel_y: got %h expected fffe", ay); else passed++;
    total++; if (az !== 16'sd1) $display("FAIL accel_z: got %h expected 0001", az); else passed++;
    total++; if (gx !== -16'sd32768) $display("FAIL gyro_x: got %h expected 8000", gx); else passed++;
    total++; if (gy !== 16'sd32767) $display("FAIL gyro_y: got %h expected 7fff", gy); else passed++;
    total++; if (gz !== 16'sd0) $display("FAIL gyro_z: got %h expected 0000", gz); else passed++;
    total++; if (wr_log[10] !== 8'h3B || wr_log[11] !== 8'h43) $display("FAIL read_regs: got %h %h expected 3b 43", wr_log[10], wr_log[11]); else passed++;
    total++; if (nsend_log[5] != 1 || rnow_log[5] != 1) $display("FAIL read_cmd: got n_send %0d read_now %0d expected 1 1", nsend_log[5], rnow_log[5]); else passed++;
    @(negedge clk);
    total++; if (sample_valid !== 1'b0) $display("FAIL sv_width: got %b expected 0", sample_valid); else passed++;
  endtask

  task automatic test_short();
    int s = sv_cnt, d = short_done;
    short_gyro = 1;
    for (int n = 0; n < 1000 && short_done == d; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    short_gyro = 0;
    total++; if (short_done == d) $display("FAIL short_timeout: got %0d expected %0d", short_done, d + 1); else passed++;
    total++; if (err !== 1'b1) $display("FAIL short_err: got %b expected 1", err); else passed++;
    total++; if (sv_cnt != s) $display("FAIL short_sv: got %0d expected %0d", sv_cnt, s); else passed++;
    total++; if (ax !== 16'sh1234 || gx !== -16'sd32768) $display("FAIL short_hold: got %h %h expected 1234 8000", ax, gx); else passed++;
  endtask

  task automatic test_back_to_back();
    int s, c;
    stretch = 250;
    for (int n = 0; n < 2000 && sample_valid !== 1'b1; n++) @(negedge clk);
    s = start_cnt; c = cyc;
    @(negedge clk);
    for (int n = 0; n < 2000 && sample_valid !== 1'b1; n++) @(negedge clk);
    stretch = 0;
    total++; if (start_cnt - s != 2) $display("FAIL b2b_starts: got %0d expected 2", start_cnt - s); else passed++;
    total++; if (cyc - c != 3 * DIV) $display("FAIL b2b_period: got %0d expected %0d", cyc - c, 3 * DIV); else passed++;
    for (int n = 0; n < 1000 && iic.en_start !== 1'b1; n++) @(negedge clk);
    total++; if (cyc - gyro_end_cyc <= 10) $display("FAIL b2b_gap: got %0d expected >10", cyc - gyro_end_cyc); else passed++;
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err); else passed++;
  endtask

  task automatic test_rst_mid();
    for (int n = 0; n < 1000 && !in_gyr; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++; if (ax !== 16'sh1234) $display("FAIL pre_rst_sample: got %h expected 1234", ax); else passed++;
    test_reset(1);
    test_pwrup();
    for (int n = 0; n < 1000 && init_done !== 1'b1; n++) @(negedge clk);
    total++; if (init_done !== 1'b1) $display("FAIL reinit_done: got %b expected 1", init_done); else passed++;
  endtask

`ifdef MPU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    hang_third = 1; init_wr_cnt = 0;
    test_reset(2);
    for (int n = 0; n < 1000 && err !== 1'b1; n++) @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL to_err: got %b expected 1", err); else passed++;
    total++; if (wr_log.size() != 6) $display("FAIL to_bytes: got %0d expected 6", wr_log.size()); else passed++;
    @(negedge clk);
    for (int n = 0; n < 500 && iic.en_start !== 1'b1; n++) @(negedge clk);
    total++; if (iic.tx_data !== 8'h6B) $display("FAIL to_restart: got %h expected 6b", iic.tx_data); else passed++;
    hang_third = 0;
    for (int n = 0; n < 2000 && init_done !== 1'b1; n++) @(negedge clk);
    total++; if (init_done !== 1'b1) $display("FAIL to_init_done: got %b expected 1", init_done); else passed++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset(3);
    test_pwrup();
    test_init();
    test_sample();
    test_short();
    test_back_to_back();
    test_rst_mid();
`ifdef MPU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
